// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank: register word indices,
// the register word type and a helper to form byte offsets from word indices.
// Imported by mmio_gpio_bank, gpio_debounce and the bench.
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 32;

  // Word indices inside the 32-byte window (byte offset = index * 4).
  localparam logic [2:0] GPIO_OUT  = 3'd0;  // 0x00 output data
  localparam logic [2:0] GPIO_DIR  = 3'd1;  // 0x04 direction, 1 = output
  localparam logic [2:0] GPIO_IN   = 3'd2;  // 0x08 filtered pin state, read-only
  localparam logic [2:0] GPIO_RISE = 3'd3;  // 0x0C rise-detect enable
  localparam logic [2:0] GPIO_FALL = 3'd4;  // 0x10 fall-detect enable
  localparam logic [2:0] GPIO_STAT = 3'd5;  // 0x14 edge status, write-1-to-clear
  localparam logic [2:0] GPIO_MASK = 3'd6;  // 0x18 interrupt mask
  localparam logic [2:0] GPIO_SET  = 3'd7;  // 0x1C OUT |= wr_data, write-only

  typedef logic [31:0] gpio_reg_t;

  // Byte offset of a register given its word index.
  function automatic logic [4:0] gpio_addr(input logic [2:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce filter: out follows in only after in has differed from
// out for CYCLES consecutive clocks; any return to the current out value
// restarts the count. Latency CYCLES clocks; no backpressure.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int CYCLES = 1200
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count consecutive cycles of disagreement; accept the new level at CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      out <= in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR/IN/RISE/FALL/STAT/MASK/SET registers,
// 2-flop input synchronisers, edge capture and a registered level irq.
// Define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter after the sync.
module mmio_gpio_bank
  import gpio_pkg::*;
#(
  parameter int GPIO_PINS       = 32,
  parameter int DEBOUNCE_CYCLES = 1200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [4:0]           addr,
  input  logic                 wr_ena,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  inout  wire  [GPIO_PINS-1:0] gpio_pins,
  output logic                 irq
);

  localparam int P = GPIO_PINS;

  logic [P-1:0] out_q, dir_q, rise_q, fall_q, stat_q, mask_q;
  logic [P-1:0] s1, s2, filt, prev;
  logic [P-1:0] rise_hit, fall_hit, wr_bits, rd_val;
  logic [2:0]   idx;
  logic         wr;
  gpio_reg_t    rd_word;
  logic         unused_addr_lsb;

  assign idx             = addr[4:2];
  assign wr              = sel & wr_ena;
  assign wr_bits         = wr_data[P-1:0];  // bits above the pin count are dropped
  assign unused_addr_lsb = ^addr[1:0];

  // Edge detection on the filtered level against its previous-cycle value.
  assign rise_hit = filt & ~prev & rise_q;
  assign fall_hit = ~filt & prev & fall_q;

  // Software-visible control registers; SET only ORs into OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      mask_q <= '0;
    end else if (wr) begin
      case (idx)
        GPIO_OUT:  out_q  <= wr_bits;
        GPIO_DIR:  dir_q  <= wr_bits;
        GPIO_RISE: rise_q <= wr_bits;
        GPIO_FALL: fall_q <= wr_bits;
        GPIO_MASK: mask_q <= wr_bits;
        GPIO_SET:  out_q  <= out_q | wr_bits;
        default:   ;
      endcase
    end
  end

  // Edge status: W1C first, then newly captured edges OR in so a set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else if (wr && idx == GPIO_STAT) begin
      stat_q <= (stat_q & ~wr_bits) | rise_hit | fall_hit;
    end else begin
      stat_q <= stat_q | rise_hit | fall_hit;
    end
  end

  // Registered interrupt request from masked status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(stat_q & mask_q);
    end
  end

  // Two-flop synchroniser on the pads plus the previous filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= gpio_pins;
      s2   <= s1;
      prev <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < P; i++) begin : g_deb
    gpio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk (clk),
      .rst (rst),
      .in  (s2[i]),
      .out (filt[i])
    );
  end
`else
  assign filt = s2;
`endif

  // Pads are driven only where the direction bit selects output.
  for (genvar i = 0; i < P; i++) begin : g_pad
    assign gpio_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // Read mux: unmapped and write-only offsets return 0.
  always_comb begin
    rd_val = '0;
    case (idx)
      GPIO_OUT:  rd_val = out_q;
      GPIO_DIR:  rd_val = dir_q;
      GPIO_IN:   rd_val = filt;
      GPIO_RISE: rd_val = rise_q;
      GPIO_FALL: rd_val = fall_q;
      GPIO_STAT: rd_val = stat_q;
      GPIO_MASK: rd_val = mask_q;
      default:   rd_val = '0;
    endcase
  end

  // Zero-extend to the bus width and gate with the chip select.
  always_comb begin
    rd_word        = '0;
    rd_word[P-1:0] = rd_val;
    rd_data        = sel ? rd_word : '0;
  end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank with 8 pins: register access, pad drive and
// readback, edge capture timing, W1C vs edge collision, irq masking, async reset.
// Optional debounce checks run when GPIO_DEBOUNCE_EN is defined.
module tb_mmio_gpio_bank;
  import gpio_pkg::*;

  localparam int PINS = 8;
  localparam int DB   = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            sel;
  logic [4:0]      addr;
  logic            wr_ena;
  logic [31:0]     wr_data;
  logic [31:0]     rd_data;
  wire  [PINS-1:0] pins;
  logic            irq;
  logic [PINS-1:0] tb_oe;
  logic [PINS-1:0] tb_val;

  int        n_cmp = 0;
  int        n_bad = 0;
  gpio_reg_t exp_q[$];
  string     tag_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < PINS; g++) begin : g_drv
    assign pins[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  mmio_gpio_bank #(.GPIO_PINS(PINS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .addr      (addr),
    .wr_ena    (wr_ena),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .gpio_pins (pins),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    sel     = 1'b1;
    wr_ena  = 1'b1;
    addr    = gpio_addr(idx);
    wr_data = d;
    @(posedge clk);
    #1;
    sel     = 1'b0;
    wr_ena  = 1'b0;
    wr_data = '0;
  endtask

  // Push the expectation when the read is issued, pop it when rd_data settles.
  task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    sel    = 1'b1;
    wr_ena = 1'b0;
    addr   = gpio_addr(idx);
    #1;
    chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    sel = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    sel     = 1'b0;
    wr_ena  = 1'b0;
    addr    = '0;
    wr_data = '0;
    tb_oe   = '1;
    tb_val  = '0;
    #2 rst  = 1'b1;

    // Reset state: all registers 0, irq low, pads released.
    tick(2);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pins", {24'd0, pins}, 32'd0);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_rd%0d", i), 3'(i), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Output drive, SET, overwrite, unused bits dropped.
    tb_oe = '0;
    wr(GPIO_DIR, 32'hFFFF_FFFF);
    rd("dir_trunc", GPIO_DIR, 32'h0000_00FF);
    wr(GPIO_OUT, 32'h0000_00A5);
    wr(GPIO_SET, 32'h0000_0100);
    rd("out_set_drop", GPIO_OUT, 32'h0000_00A5);
    chk("pins_a5", {24'd0, pins}, 32'h0000_00A5);
    rd("set_reads0", GPIO_SET, 32'd0);
    wr(GPIO_SET, 32'h0000_0042);
    rd("out_set_or", GPIO_OUT, 32'h0000_00E7);
    wr(GPIO_OUT, 32'h0000_003C);
    rd("out_overwrite", GPIO_OUT, 32'h0000_003C);
    tick(LAT);
    rd("in_readback", GPIO_IN, 32'h0000_003C);

    // Mixed direction: low nibble from OUT, high nibble from the bench.
    wr(GPIO_DIR, 32'h0000_000F);
    tb_oe  = 8'hF0;
    tb_val = 8'h90;
    #1;
    chk("pins_mixed", {24'd0, pins}, 32'h0000_009C);
    tick(LAT);
    rd("in_mixed", GPIO_IN, 32'h0000_009C);

    // Writes without select and writes to IN have no effect; deselected read is 0.
    sel = 1'b0; wr_ena = 1'b1; addr = gpio_addr(GPIO_OUT); wr_data = 32'hFF;
    tick();
    wr_ena = 1'b0;
    rd("nosel_wr", GPIO_OUT, 32'h0000_003C);
    addr = gpio_addr(GPIO_OUT);
    #1;
    chk("nosel_rd", rd_data, 32'd0);
    wr(GPIO_IN, 32'hFF);
    rd("in_ro", GPIO_IN, 32'h0000_009C);

    // Rise capture timing: IN after k+1, STAT after k+2, irq after k+3.
    wr(GPIO_DIR, 32'd0);
    tb_oe  = '1;
    tb_val = '0;
    tick(LAT + 2);
    wr(GPIO_RISE, 32'h1);
    wr(GPIO_MASK, 32'h1);
    rd("stat_idle", GPIO_STAT, 32'd0);
    tb_val = 8'h01;
    tick(LAT - 1);
    rd("in_not_yet", GPIO_IN, 32'd0);
    tick();
    rd("in_rise", GPIO_IN, 32'h1);
    rd("stat_not_yet", GPIO_STAT, 32'd0);
    tick();
    rd("stat_rise", GPIO_STAT, 32'h1);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(GPIO_STAT, 32'h1);
    rd("stat_w1c", GPIO_STAT, 32'd0);
    chk("irq_lag", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // New rise and W1C on the same edge: the set wins.
    tb_val = 8'h00;
    tick(LAT + 2);
    rd("stat_nofall", GPIO_STAT, 32'd0);
    tb_val = 8'h01;
    tick(LAT);
    wr(GPIO_STAT, 32'h1);
    rd("stat_set_wins", GPIO_STAT, 32'h1);
    tick();
    wr(GPIO_STAT, 32'h1);
    rd("stat_w1c2", GPIO_STAT, 32'd0);

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch is filtered out; a long enough pulse passes.
    tb_val = 8'h00;
    tick(LAT + 4);
    wr(GPIO_STAT, 32'h1);
    tb_val = 8'h01;
    tick(3);
    tb_val = 8'h00;
    tick(10);
    rd("deb_short_in", GPIO_IN, 32'd0);
    rd("deb_short_stat", GPIO_STAT, 32'd0);
    tb_val = 8'h01;
    tick(5);
    rd("deb_long_wait", GPIO_IN, 32'd0);
    tick();
    rd("deb_long_in", GPIO_IN, 32'h1);
    tick();
    rd("deb_long_stat", GPIO_STAT, 32'h1);
    tick(LAT + 2);
    wr(GPIO_STAT, 32'h1);
    rd("deb_clr", GPIO_STAT, 32'd0);
`endif

    // Fall capture; disabling detection keeps STAT; MASK gates irq next edge.
    wr(GPIO_FALL, 32'h1);
    wr(GPIO_RISE, 32'h0);
    tb_val = 8'h00;
    tick(LAT + 1);
    rd("stat_fall", GPIO_STAT, 32'h1);
    wr(GPIO_FALL, 32'h0);
    rd("stat_kept", GPIO_STAT, 32'h1);
    chk("irq_fall", {31'd0, irq}, 32'd1);
    wr(GPIO_MASK, 32'h0);
    chk("irq_mask_lag", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr(GPIO_MASK, 32'h1);
    tick();
    chk("irq_unmasked", {31'd0, irq}, 32'd1);

    // Async reset while pads are driven and irq is high.
    tb_oe = '0;
    wr(GPIO_DIR, 32'hFF);
    wr(GPIO_OUT, 32'hA5);
    chk("pre_rst_pins", {24'd0, pins}, 32'h0000_00A5);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2;
    tb_oe  = '1;
    tb_val = '0;
    rst    = 1'b1;
    #1;
    chk("arst_pins", {24'd0, pins}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    rd("arst_out", GPIO_OUT, 32'd0);
    rd("arst_dir", GPIO_DIR, 32'd0);
    rd("arst_stat", GPIO_STAT, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick(LAT);
    rd("post_rst_in", GPIO_IN, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
